// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULTU = 3'b000;
  localparam logic [OP_W-1:0] OP_MULT  = 3'b001;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b011;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Single iteration of the mdu datapath: one shift-add multiply step or one
// restoring shift-subtract divide step on magnitudes.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
  // Divide: shift remainder left, trial-subtract divisor; quotient bit is returned separately
  // and the low bit of acc_next is left zero for the caller to fill.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : W1'(0));
    partial  = acc[2*WIDTH-1:WIDTH-1];
    diff     = partial - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit    = ~diff[WIDTH];
      acc_next = {(diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [W2-1:0]   acc, acc_d;
  logic [WIDTH-1:0] opnd, opnd_d;
  logic [WIDTH-1:0] a_raw, a_raw_d;
  logic            is_div, is_div_d;
  logic            neg_q, neg_q_d;
  logic            neg_r, neg_r_d;
  logic            b_zero, b_zero_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic            busy_d, done_d;

  logic [W2-1:0]   iter_acc;
  logic            iter_q;
  logic            sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]   prod;
  logic [WIDTH-1:0] quo, rem;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (iter_acc),
    .q_bit    (iter_q)
  );

  // Operand magnitudes and signs for the incoming request.
  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    mag_a  = a_neg ? (~a + WIDTH'(1)) : a;
    mag_b  = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Sign correction of the unsigned result held in the accumulator.
  always_comb begin
    prod = neg_q ? (~acc + W2'(1)) : acc;
    quo  = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem  = neg_r ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
  end

  // Next-state and next-register values.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_d    = acc;
    opnd_d   = opnd;
    a_raw_d  = a_raw;
    is_div_d = is_div;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    b_zero_d = b_zero;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU, OP_MULT: begin
              state_d  = RUN;
              cnt_d    = '0;
              is_div_d = 1'b0;
              opnd_d   = mag_a;
              acc_d    = {{WIDTH{1'b0}}, mag_b};
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = 1'b0;
              b_zero_d = 1'b0;
              a_raw_d  = a;
            end
            OP_DIVU, OP_DIV: begin
              state_d  = RUN;
              cnt_d    = '0;
              is_div_d = 1'b1;
              opnd_d   = mag_b;
              acc_d    = {{WIDTH{1'b0}}, mag_a};
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              b_zero_d = (b == '0);
              a_raw_d  = a;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = iter_acc | W2'(iter_q);
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div) begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_zero) begin
          hi_d = a_raw;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      opnd   <= opnd_d;
      a_raw  <= a_raw_d;
      is_div <= is_div_d;
      neg_q  <= neg_q_d;
      neg_r  <= neg_r_d;
      b_zero <= b_zero_d;
      hi     <= hi_d;
      lo     <= lo_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule
